// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter.
// Covers FSM states, RGB565 colour-bar palette and pattern_sel encoding.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } dvp_state_t;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_FCNT    = 2'd3;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pattern source: pixel (x, y) of the selected test pattern.
// x is 10 bits, so lines of up to 1024 pixels are supported.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 1024
) (
  input  logic [9:0]  i_x,
  input  logic [5:0]  i_y,
  input  logic [1:0]  i_sel,
  input  logic [15:0] i_frame_cnt,
  output logic [15:0] o_pix
);

  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0] w_bar;
  assign w_bar = 3'(i_x / BAR_W);

  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
    o_pix = RGB_BLACK;
    case (i_sel)
      PAT_BARS:    o_pix = bar_colour(w_bar);
      PAT_RAMP:    o_pix = {i_x[4:0], i_y, i_x[9:5]};
      PAT_CHECKER: o_pix = (i_x[5] ^ i_y[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_FCNT:    o_pix = i_frame_cnt;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera-bus transmitter: OV5640-style vsync/href/byte frames of RGB565 test patterns.
// Outputs are registered from the look-ahead position, so they line up with the registered state.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_db,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [15:0] COL_LAST    = 16'(LINE_LEN - 1);
  localparam logic [15:0] HREF_END    = 16'(2 * H_ACTIVE);
  localparam logic [15:0] LINE_LAST   = 16'(FRAME_LINES - 1);
  localparam logic [15:0] BACK_FIRST  = 16'(VSYNC_LINES);
  localparam logic [15:0] ACT_FIRST   = 16'(VSYNC_LINES + V_BACK);
  localparam logic [15:0] FRONT_FIRST = 16'(VSYNC_LINES + V_BACK + V_ACTIVE);

  // A zero-length region collapses its range, so V_BACK = 0 skips VBACK naturally.
  function automatic dvp_state_t region(input logic [15:0] line);
    if (line < BACK_FIRST)       return VSYNC;
    else if (line < ACT_FIRST)   return VBACK;
    else if (line < FRONT_FIRST) return ACTIVE;
    else                         return VFRONT;
  endfunction

  dvp_state_t  r_state, w_state_nxt;
  logic [15:0] r_col, r_line, w_col_nxt, w_line_nxt;
  logic [1:0]  r_sel;
  logic [15:0] r_frame_lat, r_frame_cnt;
  logic        r_vsync, r_href, r_done, r_busy;
  logic [7:0]  r_db;
  logic [15:0] w_pix;
  logic        w_frame_start, w_href_nxt, w_last_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    if (r_state == IDLE) begin
      if (enable) begin
        w_state_nxt = VSYNC;
        w_col_nxt   = '0;
        w_line_nxt  = '0;
      end
    end else if (r_col == COL_LAST) begin
      w_col_nxt = '0;
      if (r_line == LINE_LAST) begin
        w_line_nxt  = '0;
        w_state_nxt = enable ? VSYNC : IDLE;
      end else begin
        w_line_nxt  = r_line + 16'd1;
        w_state_nxt = region(r_line + 16'd1);
      end
    end else begin
      w_col_nxt = r_col + 16'd1;
    end
  end

  assign w_frame_start = (w_state_nxt == VSYNC) && (w_line_nxt == '0) && (w_col_nxt == '0);
  assign w_href_nxt    = (w_state_nxt == ACTIVE) && (w_col_nxt < HREF_END);
  assign w_last_nxt    = (w_state_nxt == VFRONT) && (w_line_nxt == LINE_LAST) &&
                         (w_col_nxt == COL_LAST);

  dvp_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_gen (
    .i_x         (10'(w_col_nxt >> 1)),
    .i_y         (6'(w_line_nxt - ACT_FIRST)),
    .i_sel       (r_sel),
    .i_frame_cnt (r_frame_lat),
    .o_pix       (w_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_line      <= '0;
      r_sel       <= PAT_BARS;
      r_frame_lat <= '0;
      r_frame_cnt <= '0;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_db        <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_line  <= w_line_nxt;
      // frame_cnt has already counted the previous frame when the next one starts.
      if (w_frame_start) begin
        r_sel       <= pattern_sel;
        r_frame_lat <= r_frame_cnt;
      end
      r_vsync <= (w_state_nxt == VSYNC);
      r_href  <= w_href_nxt;
      r_db    <= w_href_nxt ? (w_col_nxt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
      r_done  <= w_last_nxt;
      if (w_last_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign cmos_vsync = r_vsync;
  assign cmos_href  = r_href;
  assign cmos_db    = r_db;
  assign frame_done = r_done;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = r_busy;

endmodule
